// File: rtl/xor_tt_sequencer_if.sv
// Signal bundle between the truth-table sequencer and its environment / gate under test.
// master = the sequencer side, slave = the environment driving start and the gate output.
interface xor_tt_sequencer_if #(
  parameter int N_IN = 2
);
  logic            start_i;
  logic            dut_y_i;
  logic [N_IN-1:0] vec_o;
  logic            busy_o;
  logic            done_o;
  logic            pass_o;
  logic [N_IN:0]   err_cnt_o;
  logic            fail_seen_o;
  logic [N_IN-1:0] first_fail_o;

  modport master (
    input  start_i, dut_y_i,
    output vec_o, busy_o, done_o, pass_o, err_cnt_o, fail_seen_o, first_fail_o
  );

  modport slave (
    output start_i, dut_y_i,
    input  vec_o, busy_o, done_o, pass_o, err_cnt_o, fail_seen_o, first_fail_o
  );
endinterface

// File: rtl/xor_tt_sequencer.sv
// Truth-table sequencer: walks all 2^N_IN vectors, holds each SETTLE+1 cycles, checks reduction-XOR.
// Optional macro XOR_TT_STOP_ON_FAIL_EN ends the run at the first mismatch.
module xor_tt_sequencer #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1,
  parameter int INVERT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  xor_tt_sequencer_if.master  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] SETTLE_C = 8'(SETTLE);
  localparam logic       INV_C    = (INVERT != 0);

  state_t          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [N_IN:0]   err_q, err_d;
  logic            fail_q, fail_d;
  logic [N_IN-1:0] first_q, first_d;
  logic            pass_q, pass_d;
  logic            mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fail_q  <= 1'b0;
      first_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      first_q <= first_d;
      pass_q  <= pass_d;
    end
  end

  // X/Z on the gate output must count as a failure, hence the case inequality
  assign mismatch = (bus.dut_y_i !== ((^vec_q) ^ INV_C));

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fail_d  = fail_q;
    first_d = first_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = RUN;
          vec_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          fail_d  = 1'b0;
          first_d = '0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        if (cnt_q != SETTLE_C) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          if (mismatch) begin
            err_d  = err_q + 1'b1;
            fail_d = 1'b1;
            if (!fail_q) first_d = vec_q;
          end
`ifdef XOR_TT_STOP_ON_FAIL_EN
          if (mismatch || (&vec_q)) begin
`else
          if (&vec_q) begin
`endif
            state_d = DONE;
          end else begin
            vec_d = vec_q + 1'b1;
            cnt_d = '0;
          end
        end
      end
      DONE: begin
        // err_q already includes the final sample taken on the RUN->DONE edge
        pass_d  = (err_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.vec_o        = vec_q;
  assign bus.busy_o       = (state_q == RUN);
  assign bus.done_o       = (state_q == DONE);
  assign bus.pass_o       = pass_q;
  assign bus.err_cnt_o    = err_q;
  assign bus.fail_seen_o  = fail_q;
  assign bus.first_fail_o = first_q;

endmodule
